// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg
//   Shared definitions for the ALU issue/writeback controller: ALU select
//   codes, controller state encoding and per-op classification helpers.
package alu_issue_ctrl_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0101;
  localparam logic [3:0] ALU_OR  = 4'b0110;
  localparam logic [3:0] ALU_NOT = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_MOV = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
      ALU_NOT, ALU_XOR, ALU_SLL, ALU_MOV: is_legal_op = 1'b1;
      default:                            is_legal_op = 1'b0;
    endcase
  endfunction

  // Ops whose carry output is architecturally meaningful.
  function automatic logic writes_carry(input logic [3:0] op);
    writes_carry = (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_SLL);
  endfunction

  // Ops whose signed-overflow output is architecturally meaningful.
  function automatic logic writes_oflow(input logic [3:0] op);
    writes_oflow = (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if
//   Bundles the instruction handshake, the ALU operand/result bus and the
//   writeback report.
//   master: upstream issuer + ALU side (drives instr_*, alu_out/flags)
//   slave : the controller (drives instr_ready, alu_a/b/sel, wb_*)
interface alu_issue_ctrl_if #(
  parameter int NREGS = 8,
  parameter int DW    = 32
);
  localparam int AW = $clog2(NREGS);

  logic          instr_valid;
  logic          instr_ready;
  logic [3:0]    instr_op;
  logic [AW-1:0] instr_rd;
  logic [AW-1:0] instr_rs1;
  logic [AW-1:0] instr_rs2;
  logic [DW-1:0] instr_imm;
  logic          instr_use_imm;

  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [3:0]    alu_sel;
  logic [DW-1:0] alu_out;
  logic          alu_oflow;
  logic          alu_carry;

  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;

  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
           instr_imm, instr_use_imm,
    input  instr_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_out, alu_oflow, alu_carry,
    input  wb_valid, wb_rd, wb_data
  );

  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
           instr_imm, instr_use_imm,
    output instr_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_out, alu_oflow, alu_carry,
    output wb_valid, wb_rd, wb_data
  );

endinterface

// File: rtl/alu_issue_ctrl_reg_file.sv
// reg_file
//   NREGS x DW register file: two combinational read ports, one debug read
//   port, one synchronous write port, async active-low clear. r0 always
//   reads zero and writes to it are dropped.
//   ports: clk, rst_n, ra1/rd1, ra2/rd2, dbg_addr/dbg_data, we/wa/wd
module reg_file #(
  parameter  int NREGS = 8,
  parameter  int DW    = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra1,
  output logic [DW-1:0] rd1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd2,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd
);

  logic [DW-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  // r0 is forced at the read side so stored state never leaks out.
  assign rd1      = (ra1 == '0)      ? '0 : mem[ra1];
  assign rd2      = (ra2 == '0)      ? '0 : mem[ra2];
  assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Issue/writeback controller for an external combinational ALU. Accepts one
//   op per handshake (only in IDLE), registers operands onto the ALU bus,
//   captures the ALU result one cycle later and writes it back the cycle
//   after that. One op in flight, so no hazards exist.
//   ports: clk, rst_n (async low), bus (slave: instr/alu/wb), flag_z/c/v
//          (sticky), err_illegal (1-cycle pulse), dbg_addr/dbg_data
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter  int NREGS = 8,
  parameter  int DW    = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_ctrl_if.slave  bus,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             err_illegal,
  input  logic [AW-1:0]    dbg_addr,
  output logic [DW-1:0]    dbg_data
);

  state_t        state_q, state_d;
  logic          accept;
  logic          legal;
  logic          we;

  logic [AW-1:0] rd_q;
  logic [3:0]    op_q;
  logic [DW-1:0] res_q;
  logic          c_q, v_q;
  logic [DW-1:0] rs1_data, rs2_data;

  assign legal = is_legal_op(bus.instr_op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    bus.instr_ready = 1'b0;
    accept          = 1'b0;
    we              = 1'b0;
    case (state_q)
      IDLE: begin
        bus.instr_ready = 1'b1;
        accept          = bus.instr_valid;
        // Illegal ops are consumed but never leave IDLE.
        if (accept && legal) state_d = EXEC;
      end
      EXEC: state_d = WB;
      WB: begin
        we      = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_illegal <= 1'b0;
      rd_q        <= '0;
      op_q        <= '0;
      res_q       <= '0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      bus.alu_a   <= '0;
      bus.alu_b   <= '0;
      bus.alu_sel <= '0;
      flag_z      <= 1'b0;
      flag_c      <= 1'b0;
      flag_v      <= 1'b0;
    end else begin
      err_illegal <= accept && !legal;
      if (accept && legal) begin
        rd_q        <= bus.instr_rd;
        op_q        <= bus.instr_op;
        bus.alu_a   <= rs1_data;
        bus.alu_b   <= bus.instr_use_imm ? bus.instr_imm : rs2_data;
        bus.alu_sel <= bus.instr_op;
      end
      // ALU has had the whole EXEC cycle to settle on the registered operands.
      if (state_q == EXEC) begin
        res_q <= bus.alu_out;
        c_q   <= bus.alu_carry;
        v_q   <= bus.alu_oflow;
      end
      if (we) begin
        flag_z <= (res_q == '0);
        if (writes_carry(op_q)) flag_c <= c_q;
        if (writes_oflow(op_q)) flag_v <= v_q;
      end
    end
  end

  assign bus.wb_valid = we;
  assign bus.wb_rd    = we ? rd_q  : '0;
  assign bus.wb_data  = we ? res_q : '0;

  reg_file #(.NREGS(NREGS), .DW(DW)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra1      (bus.instr_rs1),
    .rd1      (rs1_data),
    .ra2      (bus.instr_rs2),
    .rd2      (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (we),
    .wa       (rd_q),
    .wd       (res_q)
  );

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flag_z, flag_c, flag_v, err_illegal;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_chk  = 0;
  int n_fail = 0;
  int n_push = 0;
  int n_wb   = 0;

  typedef struct packed {
    logic [2:0]  rd;
    logic [31:0] data;
  } wb_t;
  wb_t sb[$];
  wb_t mon_e;

  alu_issue_ctrl_if #(.NREGS(8), .DW(32)) bus ();

  alu_issue_ctrl #(.NREGS(8), .DW(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .flag_z      (flag_z),
    .flag_c      (flag_c),
    .flag_v      (flag_v),
    .err_illegal (err_illegal),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  // Reference combinational ALU: {carry, oflow, out}.
  function automatic logic [33:0] alu_f(input logic [3:0] sel,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] y;
    logic        c, v;
    int          sh;
    y = '0; c = 1'b0; v = 1'b0; s = '0;
    case (sel)
      ALU_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        y = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (y[31] != a[31]);
      end
      ALU_SUB: begin
        s = {1'b0, a} - {1'b0, b};
        y = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (y[31] != a[31]);
      end
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_NOT: y = ~a;
      ALU_XOR: y = a ^ b;
      ALU_SLL: begin
        sh = int'(b[4:0]);
        y  = a << sh;
        c  = (sh == 0) ? 1'b0 : a[32-sh];
      end
      ALU_MOV: y = b;
      default: y = '0;
    endcase
    return {c, v, y};
  endfunction

  always_comb begin
    {bus.alu_carry, bus.alu_oflow, bus.alu_out} = alu_f(bus.alu_sel, bus.alu_a, bus.alu_b);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Scoreboard consumer: every writeback must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.wb_valid) begin
      n_wb++;
      if (sb.size() == 0) begin
        chk("wb_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("wb_rd", 32'(bus.wb_rd), 32'(mon_e.rd));
        chk("wb_data", bus.wb_data, mon_e.data);
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 10 && !bus.instr_ready; i++) begin
      @(posedge clk); #1;
    end
    chk("ready_timeout", 32'(bus.instr_ready), 32'd1);
  endtask

  task automatic drive(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [31:0] imm, input logic use_imm);
    wait_ready();
    bus.instr_op      = op;
    bus.instr_rd      = rd;
    bus.instr_rs1     = rs1;
    bus.instr_rs2     = rs2;
    bus.instr_imm     = imm;
    bus.instr_use_imm = use_imm;
    bus.instr_valid   = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid   = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [2:0] rd,
                        input logic [2:0] rs1, input logic [2:0] rs2, input logic [31:0] imm,
                        input logic use_imm, input logic [31:0] exp_data,
                        input logic ez, input logic ec, input logic ev);
    sb.push_back({rd, exp_data});
    n_push++;
    drive(op, rd, rs1, rs2, imm, use_imm);
    chk({tag, "_busy"}, 32'(bus.instr_ready), 32'd0);
    chk({tag, "_err"}, 32'(err_illegal), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk({tag, "_z"}, 32'(flag_z), 32'(ez));
    chk({tag, "_c"}, 32'(flag_c), 32'(ec));
    chk({tag, "_v"}, 32'(flag_v), 32'(ev));
    chk({tag, "_ready"}, 32'(bus.instr_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n             = 1'b0;
    bus.instr_valid   = 1'b0;
    bus.instr_op      = '0;
    bus.instr_rd      = '0;
    bus.instr_rs1     = '0;
    bus.instr_rs2     = '0;
    bus.instr_imm     = '0;
    bus.instr_use_imm = 1'b0;
    dbg_addr          = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // reset state
    chk("rst_ready", 32'(bus.instr_ready), 32'd1);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_flags", {29'd0, flag_z, flag_c, flag_v}, 32'd0);
    chk("rst_err", 32'(err_illegal), 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_b", bus.alu_b, 32'd0);
    chk("rst_alu_sel", 32'(bus.alu_sel), 32'd0);
    for (int r = 0; r < 8; r++) begin
      dbg_addr = 3'(r); #1;
      chk("rst_reg", dbg_data, 32'd0);
    end

    // arithmetic and flag behaviour
    run_op("add_imm", ALU_ADD, 3'd1, 3'd0, 3'd0, 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0);
    run_op("add_ovf", ALU_ADD, 3'd2, 3'd1, 3'd0, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    run_op("sub_rr",  ALU_SUB, 3'd3, 3'd1, 3'd1, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    dbg_addr = 3'd2; #1;
    chk("dbg_r2", dbg_data, 32'h8000_0000);
    dbg_addr = 3'd3; #1;
    chk("dbg_r3", dbg_data, 32'h0000_0000);
    run_op("add_cv",  ALU_ADD, 3'd4, 3'd2, 3'd0, 32'h8000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b1);

    // logic ops leave carry/overflow alone
    run_op("mov",     ALU_MOV, 3'd1, 3'd0, 3'd0, 32'hF0F0_F0F0, 1'b1, 32'hF0F0_F0F0, 1'b0, 1'b1, 1'b1);
    run_op("and",     ALU_AND, 3'd5, 3'd1, 3'd0, 32'h0FF0_0FF0, 1'b1, 32'h00F0_00F0, 1'b0, 1'b1, 1'b1);
    run_op("or",      ALU_OR,  3'd5, 3'd1, 3'd0, 32'h0FF0_0FF0, 1'b1, 32'hFFF0_FFF0, 1'b0, 1'b1, 1'b1);
    run_op("xor",     ALU_XOR, 3'd5, 3'd1, 3'd0, 32'h0FF0_0FF0, 1'b1, 32'hFF00_FF00, 1'b0, 1'b1, 1'b1);
    run_op("not",     ALU_NOT, 3'd5, 3'd1, 3'd0, 32'h0000_0000, 1'b1, 32'h0F0F_0F0F, 1'b0, 1'b1, 1'b1);
    // sll updates carry (bit 24 of source shifted out last) but not overflow
    run_op("sll",     ALU_SLL, 3'd6, 3'd1, 3'd0, 32'h0000_0008, 1'b1, 32'hF0F0_F000, 1'b0, 1'b0, 1'b1);

    // write to r0 is reported but dropped
    run_op("mov5",    ALU_MOV, 3'd7, 3'd0, 3'd0, 32'h0000_0005, 1'b1, 32'h0000_0005, 1'b0, 1'b0, 1'b1);
    run_op("add_r0",  ALU_ADD, 3'd0, 3'd7, 3'd0, 32'h0000_0005, 1'b1, 32'h0000_000A, 1'b0, 1'b0, 1'b0);
    dbg_addr = 3'd0; #1;
    chk("dbg_r0", dbg_data, 32'd0);
    dbg_addr = 3'd7; #1;
    chk("dbg_r7", dbg_data, 32'h0000_0005);

    // illegal op: pulse only, state and ALU bus untouched
    drive(4'b0000, 3'd3, 3'd1, 3'd1, 32'h1234_5678, 1'b1);
    chk("ill_err", 32'(err_illegal), 32'd1);
    chk("ill_ready", 32'(bus.instr_ready), 32'd1);
    chk("ill_sel", 32'(bus.alu_sel), 32'(ALU_ADD));
    @(posedge clk); #1;
    chk("ill_err_clr", 32'(err_illegal), 32'd0);
    chk("ill_flags", {29'd0, flag_z, flag_c, flag_v}, 32'd0);
    dbg_addr = 3'd3; #1;
    chk("ill_r3", dbg_data, 32'd0);

    // reset during EXEC aborts the op (no expectation pushed)
    run_op("pre_rst", ALU_SUB, 3'd2, 3'd0, 3'd0, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    drive(ALU_ADD, 3'd4, 3'd1, 3'd0, 32'h1111_1111, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mrst_flags", {29'd0, flag_z, flag_c, flag_v}, 32'd0);
    chk("mrst_wb", 32'(bus.wb_valid), 32'd0);
    for (int r = 0; r < 8; r++) begin
      dbg_addr = 3'(r); #1;
      chk("mrst_reg", dbg_data, 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mrst_ready", 32'(bus.instr_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("mrst_flags_after", {29'd0, flag_z, flag_c, flag_v}, 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("wb_count", 32'(n_wb), 32'(n_push));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
